iq_issue_arbiter: RTL

//   Shares one ALU functional unit among NUM_QUEUES issue_queue instances.

---
 rtl/iq_issue_arbiter_pkg.sv | 31 +++
 rtl/iq_issue_arbiter_if.sv | 27 ++
 rtl/iq_issue_arbiter_rr_picker.sv | 35 +++
 rtl/iq_issue_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/iq_issue_arbiter_pkg.sv
// Shared types for the ALU issue arbiter: ALU opcode, issue-queue head entry and output-register state.
package iq_issue_arbiter_pkg;

  localparam int unsigned REG_ADDR_LEN = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } AL_FUNC;

  typedef struct packed {
    AL_FUNC                  insn;
    logic [REG_ADDR_LEN-1:0] inp1;
    logic [REG_ADDR_LEN-1:0] inp2;
    logic [REG_ADDR_LEN-1:0] dst;
  } iq_entry_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/iq_issue_arbiter_if.sv
// Issue-queue / FU handshake bundle; slave is the arbiter, master is the queues + FU side.
interface iq_issue_arbiter_if #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned QIDX_W     = $clog2(NUM_QUEUES)
);
  import iq_issue_arbiter_pkg::*;

  logic                  flush;
  logic [NUM_QUEUES-1:0] rq_ready;
  iq_entry_t             rq_entry [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] rq_issue;
  logic                  fu_stall;
  logic                  fu_valid;
  iq_entry_t             fu_entry;
  logic [QIDX_W-1:0]     fu_src;

  modport master (
    output flush, rq_ready, rq_entry, fu_stall,
    input  rq_issue, fu_valid, fu_entry, fu_src
  );

  modport slave (
    input  flush, rq_ready, rq_entry, fu_stall,
    output rq_issue, fu_valid, fu_entry, fu_src
  );

endinterface

// File: rtl/iq_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest requester at or after ptr, wrapping, via a doubled request vector.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  localparam int unsigned DW = 2 * N;

  logic [DW-1:0] dbl_masked;
  logic          found;

  // Lower copy masked below ptr; the unmasked upper copy supplies the wrap-around.
  always_comb begin
    dbl_masked = {req, req} & ~((DW'(1) << ptr) - DW'(1));
    gnt_idx    = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (!found && dbl_masked[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i % N);
      end
    end
    gnt          = '0;
    gnt[gnt_idx] = found;
  end

  assign any = |req;

endmodule

// File: rtl/iq_issue_arbiter.sv
// Round-robin arbiter sharing one ALU among several issue queues, with a single valid/stall output register.
module iq_issue_arbiter
  import iq_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned QIDX_W     = $clog2(NUM_QUEUES)
) (
  input logic               clk,
  input logic               reset,
  iq_issue_arbiter_if.slave bus
);

  out_state_e            state_q, state_d;
  iq_entry_t             fu_entry_q, fu_entry_d;
  logic [QIDX_W-1:0]     fu_src_q, fu_src_d;
  logic [QIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_QUEUES-1:0] gnt;
  logic [QIDX_W-1:0]     gnt_idx;
  logic                  any_ready;
  logic                  fu_valid;
  logic                  consume;
  logic                  can_load;
  logic                  grant;

  rr_picker #(.N(NUM_QUEUES), .PW(QIDX_W)) u_picker (
    .req     (bus.rq_ready),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_ready)
  );

  assign fu_valid = (state_q == FULL);

  // Flush dominates; otherwise a grant refills the register, a bare consume drains it.
  always_comb begin
    state_d    = state_q;
    fu_entry_d = fu_entry_q;
    fu_src_d   = fu_src_q;
    rr_ptr_d   = rr_ptr_q;
    consume    = fu_valid & ~bus.fu_stall;
    can_load   = ~bus.flush & (~fu_valid | consume);
    grant      = reset & can_load & any_ready;
    if (bus.flush) begin
      state_d = EMPTY;
    end else if (grant) begin
      state_d    = FULL;
      fu_entry_d = bus.rq_entry[gnt_idx];
      fu_src_d   = gnt_idx;
      rr_ptr_d   = (gnt_idx == QIDX_W'(NUM_QUEUES - 1)) ? '0 : gnt_idx + QIDX_W'(1);
    end else if (consume) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      fu_entry_q <= '0;
      fu_src_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fu_entry_q <= fu_entry_d;
      fu_src_q   <= fu_src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.rq_issue = grant ? gnt : '0;
  assign bus.fu_valid = fu_valid;
  assign bus.fu_entry = fu_entry_q;
  assign bus.fu_src   = fu_src_q;

endmodule
